// File: rtl/seg_pkg.sv
// Shared seven-segment glyphs, digit-slot type and saturation limit for the score display.
package seg_pkg;

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_e;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_N     = 7'h54;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [15:0] SAT_MAX = 16'd999;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] slot_ground(input slot_e s);
        return ~(4'b0001 << s);
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one iteration per clk, 16 iterations.
// Input must already be saturated to 999 so three BCD digits suffice.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    // {bcd[11:0], bin[15:0]} working register, shifted left each iteration
    logic [27:0] sr_q, sr_d, sr_adj;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < 3; i++) begin
            if (sr_q[16 + 4*i +: 4] >= 4'd5)
                sr_adj[16 + 4*i +: 4] = sr_q[16 + 4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start && !busy_q && !done_q) begin
            sr_d   = {12'd0, bin};
            cnt_d  = 4'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sr_d  = {sr_adj[26:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // The done cycle counts as busy so a new start waits until the result is taken.
    assign busy = busy_q | done_q;
    assign done = done_q;
    assign bcd  = sr_q[27:16];

endmodule

// File: rtl/score_display_mux.sv
// Four-digit multiplexed score display: player glyph plus saturated decimal stick count,
// with "End"/"Err" overlays. Define SEG_WRONG_BLINK_EN to blink the display on wrong instead of "Err".
module score_display_mux
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] datain,
    input  logic        user,
    input  logic        wrong,
    input  logic        finish,
    output logic [6:0]  display,
    output logic [3:0]  grounds
);

    localparam int            PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    slot_e         slot_q, slot_d, slot_nxt;
    logic          blank_q, blank_d;
    logic [6:0]    seg_q, seg_d, content;
    logic          user_q, wrong_q, finish_q;
    logic [15:0]   snap_q, snap_d;
    logic [11:0]   bcd_q, bcd_d;
    logic          shown_q, shown_d;
    logic          tc;

    logic          cv_start, cv_busy, cv_done;
    logic [15:0]   cv_bin;
    logic [11:0]   cv_bcd;

    assign tc       = (presc_q == PRESC_TC);
    assign slot_nxt = slot_e'(slot_q - 2'd1);

    assign cv_start = !cv_busy && (datain != snap_q);
    assign cv_bin   = (datain > SAT_MAX) ? SAT_MAX : datain;

    bin2bcd_seq u_b2b (
        .clk   (clk),
        .rst_n (rst_n),
        .start (cv_start),
        .bin   (cv_bin),
        .busy  (cv_busy),
        .done  (cv_done),
        .bcd   (cv_bcd)
    );

    // Glyph for the slot about to become active; latched only at the slot boundary.
    always_comb begin
        content = SEG_BLANK;
        if (slot_nxt == SLOT3) begin
            content = user_q ? SEG_2 : SEG_1;
        end else if (finish_q) begin
            case (slot_nxt)
                SLOT2:   content = SEG_E;
                SLOT1:   content = SEG_N;
                default: content = SEG_D;
            endcase
`ifndef SEG_WRONG_BLINK_EN
        end else if (wrong_q) begin
            case (slot_nxt)
                SLOT2:   content = SEG_E;
                default: content = SEG_R;
            endcase
`endif
        end else begin
            case (slot_nxt)
                SLOT2:   content = (bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg_digit(bcd_q[11:8]);
                SLOT1:   content = (bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg_digit(bcd_q[7:4]);
                default: content = seg_digit(bcd_q[3:0]);
            endcase
        end
        if (!shown_q)
            content = SEG_BLANK;
    end

    always_comb begin
        presc_d = tc ? '0 : presc_q + PW'(1);
        slot_d  = tc ? slot_nxt : slot_q;
        blank_d = tc;
        seg_d   = tc ? content : seg_q;
        snap_d  = cv_start ? datain : snap_q;
        bcd_d   = cv_done ? cv_bcd : bcd_q;
        shown_d = shown_q | cv_done;
    end

    // blank_q resets high so grounds read all-off during and right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            slot_q   <= SLOT3;
            blank_q  <= 1'b1;
            seg_q    <= SEG_BLANK;
            user_q   <= 1'b0;
            wrong_q  <= 1'b0;
            finish_q <= 1'b0;
            snap_q   <= 16'hFFFF;
            bcd_q    <= '0;
            shown_q  <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            slot_q   <= slot_d;
            blank_q  <= blank_d;
            seg_q    <= seg_d;
            user_q   <= user;
            wrong_q  <= wrong;
            finish_q <= finish;
            snap_q   <= snap_d;
            bcd_q    <= bcd_d;
            shown_q  <= shown_d;
        end
    end

`ifdef SEG_WRONG_BLINK_EN
    localparam int            BW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          dark_q, dark_d;

    always_comb begin
        blink_d = blink_q;
        phase_d = phase_q;
        dark_d  = dark_q;
        if (tc) begin
            if (blink_q == BLINK_TC) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + BW'(1);
            end
            dark_d = wrong_q & ~finish_q & phase_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= '0;
            phase_q <= 1'b0;
            dark_q  <= 1'b0;
        end else begin
            blink_q <= blink_d;
            phase_q <= phase_d;
            dark_q  <= dark_d;
        end
    end

    assign grounds = (blank_q | dark_q) ? 4'hF : slot_ground(slot_q);
`else
    assign grounds = blank_q ? 4'hF : slot_ground(slot_q);
`endif

    assign display = seg_q;

endmodule

// File: doc/score_display_mux.md
SCORE_DISPLAY_MUX -- requirements
Module: score_display_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clk cycles per digit slot.
REQ-002 SHALL have parameter BLINK_DIV, default 64: digit slots per blink half-period.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port datain  input  16  unsigned remaining-stick count.
REQ-006 SHALL have port user  input  1  current player (0 = player 1, 1 = player 2).
REQ-007 SHALL have port wrong  input  1  illegal-move flag.
REQ-008 SHALL have port finish  input  1  game-over flag.
REQ-009 SHALL have port display  output  7  segments a..g, display[0] = a, active-high.
REQ-010 SHALL have port grounds  output  4  digit enables, active-low one-cold, grounds[3] = leftmost digit.

Function
REQ-011 SHALL count a prescaler 0..REFRESH_DIV-1; on terminal count it wraps to 0 and advances slot index 3->2->1->0->3.
REQ-012 SHALL drive exactly one grounds bit low per slot; for one clk after each slot change, grounds SHALL be 4'b1111 (ghost blanking).
REQ-013 SHALL show on digit 3 the glyph "1" when user=0 and "2" when user=1.
REQ-014 SHALL show on digits 2..0 the decimal value of datain; values above 999 SHALL saturate to 999.
REQ-015 SHALL blank leading zeros on digits 2 and 1; digit 0 SHALL always be lit (value 0 shows "  0").
REQ-016 SHALL convert binary to BCD sequentially by shift-add-3, 16 iterations, one per clk.
REQ-017 SHALL start a conversion when idle and datain differs from the last converted snapshot; the snapshot SHALL be captured at start.
REQ-018 SHALL commit all three BCD digits to the display register atomically, 17 clk after start.
REQ-019 SHALL finish any conversion in progress when datain changes mid-conversion, commit it, then start a new conversion on the next clk.
REQ-020 SHALL give finish priority over wrong: digits 2..0 show "End" and digit 3 shows the player glyph.
REQ-021 SHALL count digit slots in a blink counter, toggling a phase bit every BLINK_DIV slots.
REQ-022 SHALL treat user/wrong/finish as level inputs sampled every clk; a change SHALL be visible from the next slot boundary.

Reset
REQ-023 SHALL, while rst_n=0, force display=7'b0000000 and grounds=4'b1111.
REQ-024 SHALL, while rst_n=0, clear the prescaler, slot index (to 3), blink counter, phase, converter and BCD register, and set the snapshot to 16'hFFFF so a conversion starts after release.
REQ-025 SHALL, on reset asserted mid-conversion, discard the partial result; display content SHALL stay blank until the first commit.

Configuration
REQ-026 SHALL, with SEG_WRONG_BLINK_EN defined and wrong=1, finish=0, blank all four digits during blink phase 1 and show normal content during phase 0.
REQ-027 SHALL, with SEG_WRONG_BLINK_EN undefined and wrong=1, finish=0, show "Err" steadily on digits 2..0 with the player glyph on digit 3; blink counter logic SHALL be absent.

Structure
REQ-028 SHALL take segment glyph constants (0-9, E, n, d, r, blank) and the slot-index type from shared package seg_pkg.
REQ-029 SHALL place the sequential converter in sub-module bin2bcd_seq with ports start, bin[15:0], busy, done, bcd[11:0].

Verification (REFRESH_DIV=4, BLINK_DIV=2)
REQ-030 SHALL verify: rst_n low, then release with datain=100, user=0 -> after 17 clk bcd=1,0,0; scan shows "1100"; each slot lasts 4 clk with a 1-clk all-high grounds gap.
REQ-031 SHALL verify: datain=7 -> digits 2,1 are blank and digit 0 shows 7.
REQ-032 SHALL verify: datain changes 100->93 at conversion cycle 5 -> "100" commits first, then "93" commits 17 clk after the second start.
REQ-033 SHALL verify: datain=16'h8005 -> digits 2..0 show "999".
REQ-034 SHALL verify: wrong=1 with SEG_WRONG_BLINK_EN -> grounds stay 4'b1111 for 2 slots, then normal for 2 slots, repeating; without the macro -> "Err" shown steadily.
REQ-035 SHALL verify: wrong=1 and finish=1 with user=1 -> "2End" shown, no blink; rst_n pulsed mid-scan -> outputs blank immediately, asynchronously.
